// File: rtl/fx_match_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fx_match_pipe
//  Description : Pipelined signed fixed-point format converter. Converts a
//                two's-complement word from (IW, IF) to (OW, OF) with a
//                selectable rounding mode and wrap/saturate overflow handling.
//                The result appears LATENCY cycles later, with per-sample and
//                sticky overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_match_pipe #(
    parameter int IW       = 13,
    parameter int IF       = 8,
    parameter int OW       = 14,
    parameter int OF       = 8,
    parameter int RND_MODE = 0,
    parameter int SAT_MODE = 0,
    parameter int LATENCY  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [IW-1:0] i_data,
    input  logic          clr_sticky,
    output logic          o_valid,
    output logic [OW-1:0] o_data,
    output logic          o_ovf,
    output logic          ovf_sticky
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (LATENCY < 1 || LATENCY > 16) begin : g_chk_latency
        $error("fx_match_pipe: LATENCY must be in 1..16");
    end
    if (RND_MODE < 0 || RND_MODE > 2) begin : g_chk_rnd
        $error("fx_match_pipe: RND_MODE must be 0, 1 or 2");
    end
    if (SAT_MODE < 0 || SAT_MODE > 1) begin : g_chk_sat
        $error("fx_match_pipe: SAT_MODE must be 0 or 1");
    end
    if (IW < 2 || OW < 2) begin : g_chk_width
        $error("fx_match_pipe: IW and OW must be at least 2");
    end
    if (IF < 0 || IF > IW || OF < 0 || OF > OW) begin : g_chk_frac
        $error("fx_match_pipe: fractional bits out of range");
    end

    // ------------------------------------------------------------------------
    // Working width: enough for the left-shifted input or the output word,
    // plus guard bits so rounding up the largest input cannot wrap.
    // ------------------------------------------------------------------------
    localparam int c_s   = IF - OF;
    localparam int c_lsh = (c_s < 0) ? -c_s : 0;
    localparam int c_rsh = (c_s > 0) ?  c_s : 0;
    localparam int c_ew  = IW + c_lsh;
    localparam int c_ww  = ((c_ew > OW) ? c_ew : OW) + 2;

    localparam logic signed [c_ww-1:0] c_max =
        $signed({{(c_ww-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [c_ww-1:0] c_min = ~c_max;

    logic signed [c_ww-1:0] w_ext;
    logic signed [c_ww-1:0] w_q;
    logic                   w_ovf;
    logic [OW-1:0]          w_res;

    // Sign-extend into the working width and align the binary point when
    // fractional bits are gained (zero-filled LSBs, exact).
    assign w_ext = $signed({{(c_ww-IW){i_data[IW-1]}}, i_data}) <<< c_lsh;

    if (c_rsh == 0) begin : g_exact
        assign w_q = w_ext;
    end else begin : g_round
        localparam logic [c_ww-1:0] c_half =
            {{(c_ww-1){1'b0}}, 1'b1} << (c_rsh - 1);
        localparam logic [c_ww-1:0] c_mask = {c_ww{1'b1}} >> (c_ww - c_rsh);
        localparam logic [c_ww-1:0] c_add  = (RND_MODE == 0) ? '0 : c_half;
        localparam logic            c_even = (RND_MODE == 2);

        logic signed [c_ww-1:0] w_sum;
        logic signed [c_ww-1:0] w_sh;
        logic                   w_tie;

        // Bias by half an output LSB (modes 1/2), then floor-shift.
        assign w_sum = w_ext + $signed(c_add);
        assign w_sh  = w_sum >>> c_rsh;
        // An exact tie is a discarded field of one followed by all zeros.
        assign w_tie = ((w_ext & c_mask) == c_half);
        // Convergent mode steers ties to the even neighbour.
        assign w_q   = {w_sh[c_ww-1:1], w_sh[0] & ~(c_even & w_tie)};
    end

    assign w_ovf = (w_q > c_max) || (w_q < c_min);

    // Wrap keeps the low bits; saturate clamps toward the quantised sign.
    always_comb begin
        w_res = w_q[OW-1:0];
        if (w_ovf && SAT_MODE == 1) begin
            w_res = w_q[c_ww-1] ? c_min[OW-1:0] : c_max[OW-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline: valid shifts every cycle, data/ovf stages load only behind a
    // valid sample so the outputs hold the last sample between valids.
    // ------------------------------------------------------------------------
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_ovf;
    logic [OW-1:0]      r_dat [LATENCY];
    logic               r_sticky;

    // Stage 1 holds the converted sample; later stages are pure delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= w_res;
                r_ovf[0] <= w_ovf;
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                    r_ovf[k] <= r_ovf[k-1];
                end
            end
        end
    end

    // Sticky overflow: a set on the same cycle as a clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (r_vld[LATENCY-1] && r_ovf[LATENCY-1]) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign o_valid    = r_vld[LATENCY-1];
    assign o_data     = r_dat[LATENCY-1];
    assign o_ovf      = r_ovf[LATENCY-1];
    assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire
